// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
// Decode maps MULT/MULTU/DIV/DIVU/MTHI/MTLO onto the md_op_e encodings below;
// md_unit takes its default latencies from MULT_LAT_DEF / DIV_LAT_DEF.
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  // Larger of the two latencies; sizes the busy counter.
  function automatic int max_lat(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit holding the architectural HI/LO.
// An issued MULT/DIV computes its result immediately into res_hi/res_lo, then
// a busy counter models the fixed latency; HI/LO are written when it expires.
// Ports:
//   clk        core clock, rising edge
//   reset      asynchronous, active-low
//   md_op      md_op_e operation from decode
//   rs_val     rs operand (dividend / multiplicand / MTHI-MTLO source)
//   rt_val     rt operand (divisor / multiplier)
//   cancel     E-stage flush: a presented op must not take effect
//   busy       high while an operation is in flight (registered)
//   stall_req  hazard-unit stall request (combinational)
//   hi, lo     architectural HI/LO registers
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        cancel,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = $clog2(max_lat(MULT_LAT, DIV_LAT) + 1);

  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  // Clear when the in-flight op is a divide by zero: HI/LO stay untouched.
  logic             upd_q, upd_d;

  // Arithmetic views of the operands.
  logic signed [63:0] rs_sx, rt_sx;
  logic [63:0]        prod_s, prod_u;
  logic [31:0]        quot_s, rem_s, quot_u, rem_u;
  logic               div_zero;

  assign rs_sx    = {{32{rs_val[31]}}, rs_val};
  assign rt_sx    = {{32{rt_val[31]}}, rt_val};
  assign prod_s   = rs_sx * rt_sx;
  assign prod_u   = {32'd0, rs_val} * {32'd0, rt_val};
  assign div_zero = (rt_val == 32'd0);

  // Signed divide is done on 64-bit views so 0x80000000 / -1 yields
  // 0x80000000 (low half of +2^31) instead of overflowing.
  always_comb begin
    quot_s = 32'd0;
    rem_s  = 32'd0;
    quot_u = 32'd0;
    rem_u  = 32'd0;
    if (!div_zero) begin
      quot_s = 32'(rs_sx / rt_sx);
      rem_s  = 32'(rs_sx % rt_sx);
      quot_u = rs_val / rt_val;
      rem_u  = rs_val % rt_val;
    end
  end

  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    upd_d    = upd_q;
    if (busy_q) begin
      // Anything presented while busy is ignored; the hazard unit stalls it.
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        if (upd_q) begin
          hi_d = res_hi_q;
          lo_d = res_lo_q;
        end
      end
    end else if (!cancel) begin
      case (md_op)
        MD_MULT: begin
          {res_hi_d, res_lo_d} = prod_s;
          cnt_d  = CNT_W'(MULT_LAT);
          busy_d = 1'b1;
          upd_d  = 1'b1;
        end
        MD_MULTU: begin
          {res_hi_d, res_lo_d} = prod_u;
          cnt_d  = CNT_W'(MULT_LAT);
          busy_d = 1'b1;
          upd_d  = 1'b1;
        end
        MD_DIV: begin
          if (!div_zero) begin
            res_hi_d = rem_s;
            res_lo_d = quot_s;
          end
          cnt_d  = CNT_W'(DIV_LAT);
          busy_d = 1'b1;
          upd_d  = !div_zero;
        end
        MD_DIVU: begin
          if (!div_zero) begin
            res_hi_d = rem_u;
            res_lo_d = quot_u;
          end
          cnt_d  = CNT_W'(DIV_LAT);
          busy_d = 1'b1;
          upd_d  = !div_zero;
        end
        MD_MTHI: hi_d = rs_val;
        MD_MTLO: lo_d = rs_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      upd_q    <= upd_d;
    end
  end

  assign busy      = busy_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign stall_req = busy_q | ((md_op != MD_NONE) & ~cancel);

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: a cycle-level reference model (absolute
// completion times, plain arithmetic) checked every cycle, plus literal
// expectations for each directed vector.
module tb_md_unit;
  import md_unit_pkg::*;

  localparam int MLAT = 5;
  localparam int DLAT = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  md_op = MD_NONE;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        cancel = 1'b0;
  logic        busy, stall_req;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  md_unit #(.MULT_LAT(MLAT), .DIV_LAT(DLAT)) dut (
    .clk(clk), .reset(reset), .md_op(md_op), .rs_val(rs_val), .rt_val(rt_val),
    .cancel(cancel), .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
  );

  int total = 0;
  int bad   = 0;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] f_mul(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint p;
    if (sgn) p = longint'($signed(a)) * longint'($signed(b));
    else     p = longint'({32'd0, a}) * longint'({32'd0, b});
    return p;
  endfunction

  // Returns {remainder, quotient}.
  function automatic logic [63:0] f_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint q, r;
    if (sgn) begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = longint'($signed(a)) % longint'($signed(b));
    end else begin
      q = longint'({32'd0, a}) / longint'({32'd0, b});
      r = longint'({32'd0, a}) % longint'({32'd0, b});
    end
    return {r[31:0], q[31:0]};
  endfunction

  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  logic        m_pend, m_pupd;
  longint      m_edge, m_done;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi <= '0; m_lo <= '0; m_phi <= '0; m_plo <= '0;
      m_pend <= 1'b0; m_pupd <= 1'b0; m_edge <= 0; m_done <= 0;
    end else begin
      m_edge <= m_edge + 1;
      if (m_pend) begin
        if (m_edge + 1 == m_done) begin
          m_pend <= 1'b0;
          if (m_pupd) begin
            m_hi <= m_phi;
            m_lo <= m_plo;
          end
        end
      end else if (!cancel) begin
        case (md_op)
          MD_MULT, MD_MULTU: begin
            {m_phi, m_plo} <= f_mul(md_op == MD_MULT, rs_val, rt_val);
            m_pend <= 1'b1; m_pupd <= 1'b1; m_done <= m_edge + 1 + MLAT;
          end
          MD_DIV, MD_DIVU: begin
            if (rt_val != 0) {m_phi, m_plo} <= f_div(md_op == MD_DIV, rs_val, rt_val);
            m_pend <= 1'b1; m_pupd <= (rt_val != 0); m_done <= m_edge + 1 + DLAT;
          end
          MD_MTHI: m_hi <= rs_val;
          MD_MTLO: m_lo <= rs_val;
          default: ;
        endcase
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  bit check_en = 1'b0;
  always @(negedge clk) begin
    if (check_en) begin
      check32("busy_vs_model", {31'd0, busy}, {31'd0, m_pend});
      check32("stall_vs_model", {31'd0, stall_req},
              {31'd0, m_pend | ((md_op != MD_NONE) & ~cancel)});
      check32("hi_vs_model", hi, m_hi);
      check32("lo_vs_model", lo, m_lo);
    end
  end

  // ---------------- stimulus ----------------
  // Present one op for a single edge, then count busy cycles (bounded).
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic c, output int nb);
    @(posedge clk); #1;
    md_op = o; rs_val = a; rt_val = b; cancel = c;
    #1;
    check32("stall_in_issue_cycle", {31'd0, stall_req}, {31'd0, !c});
    @(posedge clk); #1;
    md_op = MD_NONE; cancel = 1'b0;
    nb = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy) nb++;
      else break;
    end
  endtask

  task automatic wait_idle(output int nb);
    nb = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy) nb++;
      else break;
    end
  endtask

  initial begin
    int nb;
    repeat (3) @(posedge clk);
    #1;
    check32("reset_hi", hi, 32'h0);
    check32("reset_lo", lo, 32'h0);
    check32("reset_busy", {31'd0, busy}, 32'd0);
    check32("reset_stall", {31'd0, stall_req}, 32'd0);
    reset = 1'b1;
    check_en = 1'b1;

    run_op(MD_MULT, 32'hFFFFFFFF, 32'h2, 1'b0, nb);
    $display("MULT  ffffffff*2 busy=%0d hi=%h lo=%h", nb, hi, lo);
    check32("mult_busy_len", nb, MLAT);
    check32("mult_hi", hi, 32'hFFFFFFFF);
    check32("mult_lo", lo, 32'hFFFFFFFE);

    run_op(MD_MULTU, 32'hFFFFFFFF, 32'h2, 1'b0, nb);
    $display("MULTU ffffffff*2 busy=%0d hi=%h lo=%h", nb, hi, lo);
    check32("multu_busy_len", nb, MLAT);
    check32("multu_hi", hi, 32'h1);
    check32("multu_lo", lo, 32'hFFFFFFFE);

    run_op(MD_DIV, 32'hFFFFFFF9, 32'h2, 1'b0, nb);
    $display("DIV   -7/2 busy=%0d hi=%h lo=%h", nb, hi, lo);
    check32("div_busy_len", nb, DLAT);
    check32("div_lo", lo, 32'hFFFFFFFD);
    check32("div_hi", hi, 32'hFFFFFFFF);

    run_op(MD_MTHI, 32'h11, 32'h0, 1'b0, nb);
    run_op(MD_MTLO, 32'h22, 32'h0, 1'b0, nb);
    run_op(MD_DIVU, 32'h7, 32'h0, 1'b0, nb);
    $display("DIVU  7/0 busy=%0d hi=%h lo=%h", nb, hi, lo);
    check32("divz_busy_len", nb, DLAT);
    check32("divz_hi_kept", hi, 32'h11);
    check32("divz_lo_kept", lo, 32'h22);

    run_op(MD_MTLO, 32'h1234, 32'h0, 1'b0, nb);
    $display("MTLO  1234 busy=%0d hi=%h lo=%h", nb, hi, lo);
    check32("mtlo_no_busy", nb, 0);
    check32("mtlo_lo", lo, 32'h1234);

    // MTHI presented while a MULT is in flight must be dropped.
    @(posedge clk); #1;
    md_op = MD_MULT; rs_val = 32'd3; rt_val = 32'd4;
    @(posedge clk); #1;
    md_op = MD_MTHI; rs_val = 32'hDEAD;
    #1;
    check32("stall_while_busy", {31'd0, stall_req}, 32'd1);
    @(posedge clk); #1;
    md_op = MD_NONE;
    wait_idle(nb);
    $display("MULT  3*4 with MTHI during busy: hi=%h lo=%h", hi, lo);
    check32("mthi_ignored_hi", hi, 32'h0);
    check32("mult34_lo", lo, 32'hC);

    run_op(MD_MULT, 32'd5, 32'd5, 1'b1, nb);
    $display("MULT  5*5 cancelled busy=%0d hi=%h lo=%h", nb, hi, lo);
    check32("cancel_no_busy", nb, 0);
    check32("cancel_hi", hi, 32'h0);
    check32("cancel_lo", lo, 32'hC);

    run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, nb);
    $display("DIV   80000000/ffffffff hi=%h lo=%h", hi, lo);
    check32("divovf_lo", lo, 32'h80000000);
    check32("divovf_hi", hi, 32'h0);

    run_op(MD_DIV, 32'd7, 32'hFFFFFFFE, 1'b0, nb);
    $display("DIV   7/-2 hi=%h lo=%h", hi, lo);
    check32("divneg_lo", lo, 32'hFFFFFFFD);
    check32("divneg_hi", hi, 32'h1);

    run_op(MD_DIVU, 32'hFFFFFFFF, 32'd10, 1'b0, nb);
    $display("DIVU  ffffffff/10 hi=%h lo=%h", hi, lo);
    check32("divu_lo", lo, 32'h19999999);
    check32("divu_hi", hi, 32'h5);

    // Reset asserted a few cycles into a DIV.
    @(posedge clk); #1;
    md_op = MD_DIV; rs_val = 32'd100; rt_val = 32'd7;
    @(posedge clk); #1;
    md_op = MD_NONE;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    $display("RESET mid-DIV busy=%0d hi=%h lo=%h", busy, hi, lo);
    check32("rst_mid_busy", {31'd0, busy}, 32'd0);
    check32("rst_mid_hi", hi, 32'h0);
    check32("rst_mid_lo", lo, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (DLAT + 2) @(posedge clk);
    #1;
    check32("post_reset_lo", lo, 32'h0);

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
